fifo_param: RTL

Parametrised synchronous FIFO; next generation of the 32-bit cosimulated `fifo`, keeping its write/output-enable port style. Adds configurable width and depth, status flags, programmable almost-full/almost-empty thresholds, an occupancy count and sticky error flags. It drops into the MyHDL cosimulation top level as a DUT. Its status outputs go to MyHDL alongside `data_out`.

---
 rtl/fifo_param.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with registered status flags,
// occupancy count, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow error flags.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through read mode.
// In that mode data_out always shows the head word, or 0 when empty.
// Leave FIFO_FWFT_EN undefined for the standard mode, where data_out is
// loaded only on an accepted read.
//
// Reset `rst` is synchronous and active-low. The storage array is not cleared.
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2,
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  signal_wr,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    logic                  wr_ok;
    logic                  rd_ok;
    logic [AW-1:0]         wr_ptr_nxt;
    logic [AW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         count_nxt;
    logic [DATA_WIDTH-1:0] dout_nxt;

    // Request acceptance; a pop frees a slot for a same-cycle write when full.
    always_comb begin
        rd_ok = signal_oe & ~empty;
        wr_ok = signal_wr & (~full | rd_ok);
    end

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (wr_ok) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

`ifdef FIFO_FWFT_EN
    // Next displayed head word; a word written into the head slot this cycle
    // bypasses the array so it is visible right after the writing edge.
    always_comb begin
        dout_nxt = '0;
        if (count_nxt != '0) begin
            if (wr_ok && (wr_ptr == rd_ptr_nxt)) begin
                dout_nxt = data_in;
            end else begin
                dout_nxt = mem[rd_ptr_nxt];
            end
        end
    end
`else
    // Next output word: load the head on an accepted read, otherwise hold.
    always_comb begin
        dout_nxt = data_out;
        if (rd_ok) begin
            dout_nxt = mem[rd_ptr];
        end
    end
`endif

    // Storage array write port; no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, count, output data and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            data_out     <= dout_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
            overflow     <= overflow  | (signal_wr & ~wr_ok);
            underflow    <= underflow | (signal_oe & ~rd_ok);
        end
    end

endmodule
